// File: rtl/ram_lcu_row_dp_param.sv
// Dual-port LCU row-buffer RAM: per-byte writes, valid-qualified registered reads,
// read-first cross-port collisions, port A byte priority, and a whole-array clear engine.
module ram_lcu_row_dp_param #(
   parameter int unsigned           WORD_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 6,
   parameter int unsigned           OUT_REG    = 0,
   parameter logic [WORD_WIDTH-1:0] CLR_VAL    = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr_i,
   output logic                    busy_o,
   input  logic                    cena_i,
   input  logic                    wena_i,
   input  logic [WORD_WIDTH/8-1:0] bea_i,
   input  logic [ADDR_WIDTH-1:0]   addra_i,
   input  logic [WORD_WIDTH-1:0]   dataa_i,
   output logic [WORD_WIDTH-1:0]   dataa_o,
   output logic                    vala_o,
   input  logic                    cenb_i,
   input  logic                    wenb_i,
   input  logic [WORD_WIDTH/8-1:0] beb_i,
   input  logic [ADDR_WIDTH-1:0]   addrb_i,
   input  logic [WORD_WIDTH-1:0]   datab_i,
   output logic [WORD_WIDTH-1:0]   datab_o,
   output logic                    valb_o
);

   localparam int unsigned NB    = WORD_WIDTH / 8;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
   logic [WORD_WIDTH-1:0]   mem [DEPTH];

   logic                    rd_a, rd_b, wr_a, wr_b;
   logic                    va1, vb1;
   logic [WORD_WIDTH-1:0]   da1, db1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         IDLE: begin
            if (clr_i) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         CLEAR: begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == '1) state_nxt = IDLE;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   assign busy_o = (state == CLEAR);

   assign rd_a = !cena_i &&  wena_i && !busy_o;
   assign wr_a = !cena_i && !wena_i && !busy_o;
   assign rd_b = !cenb_i &&  wenb_i && !busy_o;
   assign wr_b = !cenb_i && !wenb_i && !busy_o;

   // Port A's byte writes are issued after port B's so A wins on overlapping bytes.
   always_ff @(posedge clk) begin
      if (busy_o) begin
         mem[clr_cnt] <= CLR_VAL;
      end else begin
         for (int unsigned k = 0; k < NB; k++) begin
            if (wr_b && beb_i[k]) mem[addrb_i][8*k +: 8] <= datab_i[8*k +: 8];
            if (wr_a && bea_i[k]) mem[addra_i][8*k +: 8] <= dataa_i[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         va1 <= 1'b0;
         vb1 <= 1'b0;
         da1 <= '0;
         db1 <= '0;
      end else begin
         va1 <= rd_a;
         vb1 <= rd_b;
         if (rd_a) da1 <= mem[addra_i];
         if (rd_b) db1 <= mem[addrb_i];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic                  va2, vb2;
         logic [WORD_WIDTH-1:0] da2, db2;

         // Second stage ignores busy_o so results already in flight still emerge.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               va2 <= 1'b0;
               vb2 <= 1'b0;
               da2 <= '0;
               db2 <= '0;
            end else begin
               va2 <= va1;
               vb2 <= vb1;
               if (va1) da2 <= da1;
               if (vb1) db2 <= db1;
            end
         end

         assign dataa_o = da2;
         assign datab_o = db2;
         assign vala_o  = va2;
         assign valb_o  = vb2;
      end else begin : g_direct
         assign dataa_o = da1;
         assign datab_o = db1;
         assign vala_o  = va1;
         assign valb_o  = vb1;
      end
   endgenerate

endmodule

// File: tb/tb_ram_lcu_row_dp_param.sv
// Bench for ram_lcu_row_dp_param: two instances (latency 1 and latency 2, different
// clear values) share stimulus; expected reads are queued and checked by a monitor.
module tb_ram_lcu_row_dp_param;

   localparam logic [31:0] CV1 = 32'h5A5A_C3C3;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_i = 1'b0;
   logic        cena, wena, cenb, wenb;
   logic [3:0]  bea, beb;
   logic [5:0]  addra, addrb;
   logic [31:0] dataa, datab;

   logic        busy0, va0, vb0, busy1, va1, vb1;
   logic [31:0] da0, db0, da1, db1;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   drop = 1'b0;
   exp_t q [4][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   ram_lcu_row_dp_param #(.WORD_WIDTH(32), .ADDR_WIDTH(6), .OUT_REG(0), .CLR_VAL(32'h0)) u0 (
      .clk(clk), .rst(rst), .clr_i(clr_i), .busy_o(busy0),
      .cena_i(cena), .wena_i(wena), .bea_i(bea), .addra_i(addra), .dataa_i(dataa),
      .dataa_o(da0), .vala_o(va0),
      .cenb_i(cenb), .wenb_i(wenb), .beb_i(beb), .addrb_i(addrb), .datab_i(datab),
      .datab_o(db0), .valb_o(vb0));

   ram_lcu_row_dp_param #(.WORD_WIDTH(32), .ADDR_WIDTH(6), .OUT_REG(1), .CLR_VAL(CV1)) u1 (
      .clk(clk), .rst(rst), .clr_i(clr_i), .busy_o(busy1),
      .cena_i(cena), .wena_i(wena), .bea_i(bea), .addra_i(addra), .dataa_i(dataa),
      .dataa_o(da1), .vala_o(va1),
      .cenb_i(cenb), .wenb_i(wenb), .beb_i(beb), .addrb_i(addrb), .datab_i(datab),
      .datab_o(db1), .valb_o(vb1));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic mon(input int i, input string nm, input logic v, input logic [31:0] d);
      exp_t e;
      if (v) begin
         if (q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s unexpected valid: got data %h, expected no valid", nm, d);
         end else begin
            e = q[i].pop_front();
            check({nm, " data"}, d, e.d);
            check({nm, " cycle"}, cyc, e.due);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, "u0 port A", va0, da0);
      mon(1, "u0 port B", vb0, db0);
      mon(2, "u1 port A", va1, da1);
      mon(3, "u1 port B", vb1, db1);
   end

   task automatic idle();
      cena = 1'b1; wena = 1'b1; bea = '0; addra = '0; dataa = '0;
      cenb = 1'b1; wenb = 1'b1; beb = '0; addrb = '0; datab = '0;
      clr_i = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_rd_a(input logic [5:0] a, input logic [31:0] x0, input logic [31:0] x1);
      cena = 1'b0; wena = 1'b1; addra = a;
      if (!drop) begin
         q[0].push_back('{x0, cyc + 1});
         q[2].push_back('{x1, cyc + 2});
      end
   endtask

   task automatic set_rd_b(input logic [5:0] a, input logic [31:0] x0, input logic [31:0] x1);
      cenb = 1'b0; wenb = 1'b1; addrb = a;
      if (!drop) begin
         q[1].push_back('{x0, cyc + 1});
         q[3].push_back('{x1, cyc + 2});
      end
   endtask

   task automatic set_wr_a(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      cena = 1'b0; wena = 1'b0; addra = a; dataa = d; bea = be;
   endtask

   task automatic set_wr_b(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
      cenb = 1'b0; wenb = 1'b0; addrb = a; datab = d; beb = be;
   endtask

   // Counts edges until each instance drops busy_o; bounded so a stuck clear still finishes.
   task automatic wait_idle(input string nm, input int exp);
      int n = 0, n0 = -1, n1 = -1;
      while ((n0 < 0 || n1 < 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (n0 < 0 && !busy0) n0 = n;
         if (n1 < 0 && !busy1) n1 = n;
      end
      check({nm, " u0 busy length"}, n0, exp);
      check({nm, " u1 busy length"}, n1, exp);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset u0 busy", busy0, 1);
      check("reset u1 busy", busy1, 1);
      check("reset u0 dataa", da0, 0);
      check("reset u0 datab", db0, 0);
      check("reset u1 dataa", da1, 0);
      check("reset u1 datab", db1, 0);
      check("reset valids", {va0, vb0, va1, vb1}, 0);
      rst = 1'b0;
      wait_idle("init clear", 64);

      // Cleared contents at both ends of the array
      set_rd_a(6'd0, 32'h0, CV1);
      set_rd_b(6'd63, 32'h0, CV1);
      step();

      // Per-byte write merge on one address from both ports
      set_wr_a(6'd5, 32'hDEAD_BEEF, 4'b1111); step();
      set_wr_b(6'd5, 32'h1122_3344, 4'b0101); step();
      set_rd_a(6'd5, 32'hDE22_BE44, 32'hDE22_BE44);
      set_rd_b(6'd5, 32'hDE22_BE44, 32'hDE22_BE44);
      step();

      // Read-first across ports
      set_wr_a(6'd9, 32'hAAAA_AAAA, 4'b1111); step();
      set_wr_a(6'd9, 32'h5555_5555, 4'b1111);
      set_rd_b(6'd9, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
      step();
      set_rd_a(6'd9, 32'h5555_5555, 32'h5555_5555); step();

      // Dual write collision: A owns bytes with bea set, B fills the rest
      set_wr_a(6'd3, 32'h0, 4'b1111); step();
      set_wr_a(6'd3, 32'h1234_5678, 4'b1100);
      set_wr_b(6'd3, 32'h9ABC_DEF0, 4'b1111);
      step();
      set_rd_b(6'd3, 32'h1234_DEF0, 32'h1234_DEF0); step();
      set_wr_a(6'd3, 32'hFFFF_FFFF, 4'b0000); step();
      set_rd_a(6'd3, 32'h1234_DEF0, 32'h1234_DEF0); step();

      // Back-to-back pipelined reads
      set_wr_a(6'd1, 32'h0000_0101, 4'b1111); set_wr_b(6'd2, 32'h0000_0202, 4'b1111); step();
      set_wr_a(6'd3, 32'h0000_0303, 4'b1111); step();
      set_rd_a(6'd1, 32'h0101, 32'h0101); step();
      set_rd_a(6'd2, 32'h0202, 32'h0202); step();
      set_rd_a(6'd3, 32'h0303, 32'h0303); step();
      repeat (3) step();

      // Clear requested mid-burst: accepted reads complete, later accesses are dropped
      set_rd_a(6'd1, 32'h0101, 32'h0101); step();
      set_rd_a(6'd2, 32'h0202, 32'h0202); clr_i = 1'b1; step();
      check("clear busy rise u0", busy0, 1);
      check("clear busy rise u1", busy1, 1);
      drop = 1'b1;
      set_rd_a(6'd3, 32'h0, 32'h0); set_rd_b(6'd2, 32'h0, 32'h0); step();
      repeat (30) begin
         set_wr_a(6'd1, 32'hFFFF_FFFF, 4'b1111); set_rd_b(6'd2, 32'h0, 32'h0);
         step();
      end
      drop = 1'b0;
      wait_idle("clr_i clear", 33);
      set_rd_a(6'd1, 32'h0, CV1); set_rd_b(6'd2, 32'h0, CV1); step();
      set_rd_a(6'd5, 32'h0, CV1); set_rd_b(6'd9, 32'h0, CV1); step();

      // Reset in the middle of a clear
      set_wr_a(6'd4, 32'hCAFE_F00D, 4'b1111); step();
      set_rd_a(6'd4, 32'hCAFE_F00D, 32'hCAFE_F00D); step();
      repeat (3) step();
      clr_i = 1'b1; step();
      repeat (20) step();
      check("mid-clear busy u0", busy0, 1);
      rst = 1'b1;
      #2;
      check("mid-clear reset u0 dataa", da0, 0);
      check("mid-clear reset u1 dataa", da1, 0);
      check("mid-clear reset busy", {busy0, busy1}, 2'b11);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_idle("post-reset clear", 64);
      set_rd_a(6'd0, 32'h0, CV1); set_rd_b(6'd4, 32'h0, CV1); step();
      set_rd_a(6'd63, 32'h0, CV1); step();

      repeat (4) step();
      for (int i = 0; i < 4; i++) check($sformatf("queue %0d drained", i), q[i].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
